// File: rtl/vga_timing_gen_if.sv
// Raster bundle between the timing generator (master) and the pixel pipeline (slave).
// FRAME exists only when FRAME_CNT_EN is defined.
interface vga_timing_gen_if #(
    parameter int ADDR_W  = 19,
    parameter int FRAME_W = 8
);
    logic              EN;
    logic [10:0]       HCNT;
    logic [10:0]       VCNT;
    logic              VGA_HS;
    logic              VGA_VS;
    logic              DE;
    logic              FSTART;
    logic              LSTART;
    logic [ADDR_W-1:0] ADDR;
`ifdef FRAME_CNT_EN
    logic [FRAME_W-1:0] FRAME;
`endif

    if (FRAME_W < 1) begin : g_bad_frame_w
        $error("vga_timing_gen_if: FRAME_W must be >= 1");
    end

    modport master (
        input  EN,
        output HCNT, VCNT, VGA_HS, VGA_VS, DE, FSTART, LSTART, ADDR
`ifdef FRAME_CNT_EN
        , output FRAME
`endif
    );

    modport slave (
        output EN,
        input  HCNT, VCNT, VGA_HS, VGA_VS, DE, FSTART, LSTART, ADDR
`ifdef FRAME_CNT_EN
        , input FRAME
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing and multiplier-free linear framebuffer address generator.
// Optional frame counter on the FRAME port is enabled by defining FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   SCALE    = 1,
    parameter int   ADDR_W   = 19,
    parameter int   FRAME_W  = 8
) (
    input  logic              PCK,
    input  logic              RST,
    vga_timing_gen_if.master  vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SAFE_SC = (SCALE > 0) ? SCALE : 1;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0]  REP_LAST   = 2'(SCALE - 1);
    localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(H_ACTIVE / SAFE_SC);

    if (!(SCALE == 1 || SCALE == 2 || SCALE == 4)) begin : g_bad_scale
        $error("vga_timing_gen: SCALE must be 1, 2 or 4");
    end
    if ((H_ACTIVE % SAFE_SC) != 0 || (V_ACTIVE % SAFE_SC) != 0) begin : g_bad_div
        $error("vga_timing_gen: active sizes must be divisible by SCALE");
    end
    if (ADDR_W < $clog2((H_ACTIVE / SAFE_SC) * (V_ACTIVE / SAFE_SC))) begin : g_bad_addr_w
        $error("vga_timing_gen: ADDR_W too small for the scaled framebuffer");
    end
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
        $error("vga_timing_gen: totals must fit the 11-bit counters");
    end
    if (FRAME_W < 1) begin : g_bad_frame_w
        $error("vga_timing_gen: FRAME_W must be >= 1");
    end

    logic [10:0]       hcnt_q, hcnt_d;
    logic [10:0]       vcnt_q, vcnt_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              de_q, de_d;
    logic              fstart_q, fstart_d;
    logic              lstart_q, lstart_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        rep_x_q, rep_x_d;
    logic [1:0]        rep_y_q, rep_y_d;
`ifdef FRAME_CNT_EN
    logic [FRAME_W-1:0] frame_q, frame_d;
`endif

    // Decode is done on the next position so every output lands with its HCNT/VCNT.
    always_comb begin
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        hs_d     = hs_q;
        vs_d     = vs_q;
        de_d     = de_q;
        fstart_d = 1'b0;
        lstart_d = 1'b0;
        addr_d   = addr_q;
        base_d   = base_q;
        rep_x_d  = rep_x_q;
        rep_y_d  = rep_y_q;
`ifdef FRAME_CNT_EN
        frame_d  = frame_q;
`endif
        if (vif.EN) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? 11'd0 : vcnt_q + 11'd1;
            end else begin
                hcnt_d = hcnt_q + 11'd1;
            end

            hs_d     = (hcnt_d >= HS_START && hcnt_d < HS_END) ? HS_POL : ~HS_POL;
            vs_d     = (vcnt_d >= VS_START && vcnt_d < VS_END) ? VS_POL : ~VS_POL;
            de_d     = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
            lstart_d = (hcnt_d == 11'd0);
            fstart_d = (hcnt_d == 11'd0) && (vcnt_d == 11'd0);

            // Line base steps one scaled row after every SCALE-th replicated line.
            if (hcnt_d == 11'd0) begin
                rep_x_d = '0;
                if (vcnt_d == 11'd0) begin
                    base_d  = '0;
                    rep_y_d = '0;
                end else if (rep_y_q == REP_LAST) begin
                    base_d  = base_q + LINE_WORDS;
                    rep_y_d = '0;
                end else begin
                    rep_y_d = rep_y_q + 2'd1;
                end
                addr_d = base_d;
            end else if (rep_x_q == REP_LAST) begin
                rep_x_d = '0;
                addr_d  = addr_q + ADDR_W'(1);
            end else begin
                rep_x_d = rep_x_q + 2'd1;
            end

`ifdef FRAME_CNT_EN
            if (fstart_d) begin
                frame_d = frame_q + FRAME_W'(1);
            end
`endif
        end
    end

    always_ff @(posedge PCK) begin
        if (!RST) begin
            hcnt_q   <= H_LAST;
            vcnt_q   <= V_LAST;
            hs_q     <= ~HS_POL;
            vs_q     <= ~VS_POL;
            de_q     <= 1'b0;
            fstart_q <= 1'b0;
            lstart_q <= 1'b0;
            addr_q   <= '0;
            base_q   <= '0;
            rep_x_q  <= '0;
            rep_y_q  <= '0;
`ifdef FRAME_CNT_EN
            frame_q  <= '0;
`endif
        end else begin
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            de_q     <= de_d;
            fstart_q <= fstart_d;
            lstart_q <= lstart_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            rep_x_q  <= rep_x_d;
            rep_y_q  <= rep_y_d;
`ifdef FRAME_CNT_EN
            frame_q  <= frame_d;
`endif
        end
    end

    assign vif.HCNT   = hcnt_q;
    assign vif.VCNT   = vcnt_q;
    assign vif.VGA_HS = hs_q;
    assign vif.VGA_VS = vs_q;
    assign vif.DE     = de_q;
    assign vif.FSTART = fstart_q;
    assign vif.LSTART = lstart_q;
    assign vif.ADDR   = addr_q;
`ifdef FRAME_CNT_EN
    assign vif.FRAME  = frame_q;
`endif
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator and linear framebuffer address generator.
- Next generation of the current fixed-640x480 address/sync block.
- Configurable resolution, porch and sync widths, and sync polarity.
- Integer pixel-replication scale for low-resolution BRAM framebuffers.
- Provides frame/line start strobes that drive note-scroll animation in the graphic pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, asserted level of VGA_HS (0 = active-low)
- VS_POL, 0, asserted level of VGA_VS
- SCALE, 1, pixel replication factor in both axes; legal values 1, 2, 4
- ADDR_W, 19, framebuffer address width; must be >= clog2((H_ACTIVE/SCALE)*(V_ACTIVE/SCALE))
- FRAME_W, 8, frame counter width (optional feature only)

Ports:
- PCK  in  1  system clock; all logic on rising edge
- RST  in  1  synchronous reset, active-low
- EN  in  1  pixel tick; raster advances only on PCK edges where EN=1
- HCNT  out  11  current x position, 0..H_TOTAL-1
- VCNT  out  11  current y position, 0..V_TOTAL-1
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- DE  out  1  display enable (position inside active area)
- FSTART  out  1  frame-start strobe
- LSTART  out  1  line-start strobe
- ADDR  out  ADDR_W  framebuffer address of the current pixel
- FRAME  out  FRAME_W  frame counter (present only with FRAME_CNT_EN)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Region order on each axis: active, front porch, sync, back porch. The active area starts at position 0.
- Reset: while RST=0 at a PCK edge, regardless of EN, the registers take these values:
  - HCNT=H_TOTAL-1, VCNT=V_TOTAL-1
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL
  - DE=0, ADDR=0, FSTART=0, LSTART=0, FRAME=0
- Reset mid-frame has the same effect: immediate return to the reset values.
- First edge after reset release with EN=1 presents (0,0).
- Counter advance on each EN=1 edge:
  - HCNT increments; at H_TOTAL-1 it wraps to 0 and VCNT increments.
  - VCNT wraps V_TOTAL-1 to 0.
- EN=0 edges: all outputs hold, except FSTART and LSTART, which clear to 0.
- All outputs are registered and updated on the same edge, so each output is consistent with the HCNT/VCNT it accompanies. There are zero cycles of skew between position and decoded signals.
- VGA_HS = HS_POL when H_ACTIVE+H_FP <= HCNT < H_ACTIVE+H_FP+H_SYNC; ~HS_POL otherwise.
- VGA_VS is decoded the same way on VCNT, independent of HCNT: VS transitions coincide with HCNT=0.
- DE = 1 iff HCNT < H_ACTIVE and VCNT < V_ACTIVE.
- LSTART = 1 for exactly one PCK cycle on an edge where the raster moves to HCNT=0, on every line including blanking lines.
- FSTART = 1 for exactly one PCK cycle on an edge where the raster moves to (0,0).
- ADDR value: when DE=1, ADDR = (VCNT/SCALE)*(H_ACTIVE/SCALE) + HCNT/SCALE.
- ADDR implementation: incremental, with no multiplier.
  - A replication counter increments ADDR every SCALE active pixels.
  - A line-base register reloads ADDR at each line start.
  - The line base advances by H_ACTIVE/SCALE only after the SCALE-th replicated line.
  - The line base resets to 0 at frame start.
- When DE=0, ADDR is don't-care and is not checked.
- Illegal parameters (SCALE not 1/2/4, or active sizes not divisible by SCALE) abort elaboration via a generate-time error.
- Target implementation size: 150-250 lines.

Optional Feature:
- Macro name: FRAME_CNT_EN.
- Defined: port FRAME exists.
  - Increments by 1 on each edge that asserts FSTART.
  - Wraps 2^FRAME_W-1 to 0.
  - Resets to 0.
- Undefined: the FRAME port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset entry/exit, defaults:
  - Hold RST=0 for 10 edges with EN=1 -> HCNT=799, VCNT=524, VGA_HS=1, VGA_VS=1, DE=0.
  - Release, first EN edge -> HCNT=0, VCNT=0, DE=1, ADDR=0, FSTART=1, LSTART=1.
- Full frame, defaults:
  - Exactly 420000 EN edges between FSTART pulses.
  - VGA_HS low for 96 pixels starting HCNT=656.
  - VGA_VS low exactly on lines 490-491.
  - DE high for 307200 edges.
  - 525 LSTART pulses per frame.
- SCALE=2 addressing -> ADDR values:
  - (1,0)=0, (2,0)=1, (639,0)=319
  - (0,1)=0, (0,2)=320
  - (639,479)=76799
- EN gating:
  - EN pattern 1,0,0,1 -> HCNT advances only on the two EN=1 edges.
  - FSTART high for exactly one PCK cycle even when EN stays 0 afterwards.
- Reset mid-frame: RST=0 for one edge at (300,200) -> HCNT=799, VCNT=524, DE=0; next EN edge -> (0,0) with FSTART=1.
- FRAME_CNT_EN with FRAME_W=4:
  - Run 17 frames from reset -> FRAME sequence 1..15, 0, 1.
  - Without the macro, the build has no FRAME port and the other checks pass unchanged.
